// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the multi-channel fabric clock generator.
package clock_gen_pkg;

   typedef enum logic [1:0] {
      LOCKING = 2'd0,
      LOCKED  = 2'd1,
      RECONF  = 2'd2
   } state_t;

   // High-phase length of a divided clock; odd divisors get the extra cycle high.
   function automatic logic [31:0] hi_of(input logic [31:0] div);
      return (div + 32'd1) >> 1;
   endfunction

   function automatic logic cfg_req_ok(input logic [31:0] ch,
                                       input logic [31:0] div,
                                       input logic [31:0] phase,
                                       input logic [31:0] num_ch);
      return (div != 32'd0) && (phase < div) && (ch < num_ch);
   endfunction

endpackage

// File: rtl/clock_gen_multi_if.sv
// Configuration port of the clock generator: valid/ready request plus reject pulse.
interface clock_gen_multi_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_phase;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_phase,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/clock_div_channel.sv
// One divided-clock channel: divisor/phase registers, cycle counter, clock and enable.
module clock_div_channel
   import clock_gen_pkg::*;
#(
   parameter int DIV_W    = 8,
   parameter int INIT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             reload,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   output logic             clk_out,
   output logic             clk_en
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] phase;
   logic [DIV_W:0]   hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         div   <= DIV_W'(INIT_DIV);
         phase <= '0;
      end else begin
         if (wr) begin
            div   <= wr_div;
            phase <= wr_phase;
         end
         // Reload uses the stored phase, so a channel written on the previous edge
         // realigns to its new phase.
         if (reload) begin
            cnt <= phase;
         end else if (run) begin
            cnt <= (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
         end
      end
   end

   assign hi      = (DIV_W+1)'(hi_of(32'(div)));
   assign clk_out = ({1'b0, cnt} < hi);
   assign clk_en  = (cnt == '0);

endmodule

// File: rtl/clock_gen_multi.sv
// Portable multi-channel clock generator with runtime reconfiguration and lock sequencing.
//   state   | meaning
//   LOCKING | counters running, counting stable cycles toward lock
//   LOCKED  | outputs stable, config port open
//   RECONF  | one cycle: all channels reload their phase, lock counter clears
module clock_gen_multi
   import clock_gen_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 8,
   parameter int INIT_DIV    = 2,
   parameter int LOCK_CYCLES = 16,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   clock_gen_multi_if.slave   cfg,
   output logic [NUM_CH-1:0]  clk_out,
   output logic [NUM_CH-1:0]  clk_en,
   output logic               locked
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);

   state_t          state, state_nxt;
   logic [LW-1:0]   lock_cnt, lock_cnt_nxt;
   logic            err_q, err_nxt;
   logic            accept;
   logic            req_ok;
   logic            run;
   logic            reload;
   logic [NUM_CH-1:0] wr;

   assign accept = cfg.cfg_valid && (state == LOCKED);
   assign req_ok = cfg_req_ok(32'(cfg.cfg_ch), 32'(cfg.cfg_div),
                              32'(cfg.cfg_phase), 32'(NUM_CH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOCKING;
         lock_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_cnt <= lock_cnt_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      err_nxt      = 1'b0;
      case (state)
         LOCKING: begin
            if (lock_cnt != LW'(LOCK_CYCLES)) begin
               lock_cnt_nxt = lock_cnt + LW'(1);
            end
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (accept) begin
               if (req_ok) begin
                  state_nxt = RECONF;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RECONF: begin
            lock_cnt_nxt = '0;
            state_nxt    = LOCKING;
         end
         default: begin
            lock_cnt_nxt = '0;
            state_nxt    = LOCKING;
         end
      endcase
   end

   assign locked        = (state == LOCKED);
   assign cfg.cfg_ready = (state == LOCKED);
   assign cfg.cfg_err   = err_q;
   assign run           = (state != RECONF);
   assign reload        = (state == RECONF);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr[i] = accept && req_ok && (cfg.cfg_ch == CH_W'(i));

      clock_div_channel #(
         .DIV_W    (DIV_W),
         .INIT_DIV (INIT_DIV)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .run      (run),
         .reload   (reload),
         .wr       (wr[i]),
         .wr_div   (cfg.cfg_div),
         .wr_phase (cfg.cfg_phase),
         .clk_out  (clk_out[i]),
         .clk_en   (clk_en[i])
      );
   end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Bench for clock_gen_multi: directed scenarios plus random reconfiguration against a timeline model.
module tb_clock_gen_multi;

   localparam int NUM_CH   = 3;
   localparam int DIV_W    = 8;
   localparam int INIT_DIV = 2;
   localparam int LC       = 16;
   localparam int CH_W     = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clock_gen_multi_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg_bus ();
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] clk_en;
   logic              locked;

   clock_gen_multi #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .INIT_DIV    (INIT_DIV),
      .LOCK_CYCLES (LC),
      .CH_W        (CH_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg     (cfg_bus.slave),
      .clk_out (clk_out),
      .clk_en  (clk_en),
      .locked  (locked)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Timeline model: each channel's count is phase + cycles elapsed since the
   // last realignment, modulo its divisor; lock is a deadline in cycles.
   int m_div   [NUM_CH];
   int m_phase [NUM_CH];
   int t_align, t_lock, t_skip;
   bit err_at [int];

   function automatic int m_cnt(int ch, int t);
      int e = t - t_align;
      if (e < 0) return 0;
      return (m_phase[ch] + e) % m_div[ch];
   endfunction

   function automatic logic [NUM_CH-1:0] exp_out(int t);
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = (m_cnt(c, t) < (m_div[c] + 1) / 2);
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_en(int t);
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = (m_cnt(c, t) == 0);
      return r;
   endfunction

   function automatic logic [2:0] exp_status(int t);
      logic l;
      l = (t >= t_lock);
      return {l, l, logic'(err_at.exists(t))};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_div[c]   = INIT_DIV;
         m_phase[c] = 0;
      end
      t_align = 0;
      t_lock  = LC;
      t_skip  = -1;
      err_at.delete();
      cyc = 0;
   endtask

   // Advance one cycle; the model observes any request taken at this edge.
   task automatic tick();
      bit acc;
      int ch;
      acc = 0;
      if (cfg_bus.cfg_valid === 1'b1 && cyc >= t_lock) begin
         acc = 1;
         ch  = int'(cfg_bus.cfg_ch);
         if (ch < NUM_CH && cfg_bus.cfg_div != 0 && cfg_bus.cfg_phase < cfg_bus.cfg_div) begin
            m_div[ch]   = int'(cfg_bus.cfg_div);
            m_phase[ch] = int'(cfg_bus.cfg_phase);
            t_align     = cyc + 2;
            t_lock      = cyc + 2 + LC;
            t_skip      = cyc + 1;
         end else begin
            err_at[cyc + 1] = 1;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (acc) cfg_bus.cfg_valid = 1'b0;
   endtask

   task automatic req(int ch, int dv, int ph);
      cfg_bus.cfg_ch    = CH_W'(ch);
      cfg_bus.cfg_div   = DIV_W'(dv);
      cfg_bus.cfg_phase = DIV_W'(ph);
      cfg_bus.cfg_valid = 1'b1;
   endtask

   task automatic test_reset();
      logic [2*NUM_CH-1:0] ones;
      ones = '1;
      rst_n = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0; cfg_bus.cfg_phase = '0;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== 3'b000)
         $display("FAIL reset_stat got=%b want=000", {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err});
      else n_pass++;
      n_total++;
      if ({clk_out, clk_en} !== ones) $display("FAIL reset_clk got=%b want=%b", {clk_out, clk_en}, ones);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 24; k++) begin
         n_total++;
         if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
            $display("FAIL boot_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
         else n_pass++;
         n_total++;
         if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
            $display("FAIL boot_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
         else n_pass++;
         if (cyc == LC - 1 || cyc == LC) begin
            n_total++;
            if (locked !== (cyc == LC)) $display("FAIL boot_lock_edge cyc=%0d got=%b", cyc, locked);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_reconfig();
      int t0;
      logic [4:0] pat;
      pat = 5'b11100;
      t0 = cyc;
      req(1, 5, 0);
      for (int k = 0; k < LC + 6; k++) begin
         tick();
         if (cyc != t_skip) begin
            n_total++;
            if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
               $display("FAIL reconf_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
            else n_pass++;
         end
         n_total++;
         if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
            $display("FAIL reconf_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
         else n_pass++;
         if (cyc >= t0 + 2 && cyc <= t0 + 6) begin
            n_total++;
            if (clk_out[1] !== pat[4 - (cyc - t0 - 2)])
               $display("FAIL div5_pattern cyc=%0d got=%b want=%b", cyc, clk_out[1], pat[4 - (cyc - t0 - 2)]);
            else n_pass++;
         end
         if (cyc == t0 + 1 || cyc == t0 + 18) begin
            n_total++;
            if (locked !== (cyc == t0 + 18)) $display("FAIL reconf_lock cyc=%0d got=%b", cyc, locked);
            else n_pass++;
         end
      end
   endtask

   task automatic test_phase();
      int t0;
      req(2, 4, 0);
      for (int k = 0; k < LC + 4; k++) tick();
      t0 = cyc;
      req(0, 4, 2);
      for (int k = 0; k < LC + 6; k++) begin
         tick();
         if (cyc != t_skip) begin
            n_total++;
            if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
               $display("FAIL phase_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
            else n_pass++;
         end
         if (cyc == t0 + 2 || cyc == t0 + 3 || cyc == t0 + 4) begin
            n_total++;
            if ({clk_out[0], clk_en[0]} !== ((cyc == t0 + 4) ? 2'b11 : 2'b00))
               $display("FAIL phase_ch0 cyc=%0d got=%b", cyc, {clk_out[0], clk_en[0]});
            else n_pass++;
         end
         if (cyc == t0 + 2) begin
            n_total++;
            if (clk_en[2] !== 1'b1) $display("FAIL phase_ch2_lead got=%b want=1", clk_en[2]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_invalid();
      int t0;
      int bad [3][3] = '{'{0, 0, 0}, '{1, 6, 6}, '{3, 3, 0}};
      for (int r = 0; r < 3; r++) begin
         t0 = cyc;
         req(bad[r][0], bad[r][1], bad[r][2]);
         for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
               $display("FAIL inval_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
            else n_pass++;
            n_total++;
            if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== {2'b11, logic'(cyc == t0 + 1)})
               $display("FAIL inval_stat req=%0d cyc=%0d got=%b", r, cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err});
            else n_pass++;
         end
      end
   endtask

   task automatic test_hold_and_div1();
      int t0;
      t0 = cyc;
      req(1, 3, 1);
      repeat (3) tick();
      req(2, 1, 0);
      for (int k = 0; k < 2 * LC + 10; k++) begin
         tick();
         if (cyc != t_skip) begin
            n_total++;
            if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
               $display("FAIL hold_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
            else n_pass++;
         end
         n_total++;
         if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
            $display("FAIL hold_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
         else n_pass++;
         if (cyc == t0 + 18 || cyc == t0 + 19) begin
            n_total++;
            if (locked !== (cyc == t0 + 18)) $display("FAIL hold_accept cyc=%0d locked=%b", cyc, locked);
            else n_pass++;
         end
         if (cyc > t0 + 20) begin
            n_total++;
            if ({clk_out[2], clk_en[2]} !== 2'b11) $display("FAIL div1 cyc=%0d got=%b want=11", cyc, {clk_out[2], clk_en[2]});
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 12; r++) begin
         req($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         n = 0;
         while (cfg_bus.cfg_valid === 1'b1 && n < 60) begin
            tick();
            n++;
            if (cyc != t_skip) begin
               n_total++;
               if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
                  $display("FAIL rand_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
               else n_pass++;
            end
            n_total++;
            if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
               $display("FAIL rand_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
            else n_pass++;
         end
         if (cfg_bus.cfg_valid === 1'b1) begin
            n_total++;
            $display("FAIL rand_timeout req=%0d got=pending want=accepted", r);
            cfg_bus.cfg_valid = 1'b0;
         end
         repeat ($urandom_range(0, 20)) begin
            tick();
            if (cyc != t_skip) begin
               n_total++;
               if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
                  $display("FAIL rand_idle_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
               else n_pass++;
            end
            n_total++;
            if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
               $display("FAIL rand_idle_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_in_reconf();
      logic [2*NUM_CH-1:0] ones;
      ones = '1;
      for (int k = 0; k < LC + 4 && cyc < t_lock; k++) tick();
      req(0, 3, 1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== 3'b000)
         $display("FAIL rst_reconf_stat got=%b want=000", {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err});
      else n_pass++;
      n_total++;
      if ({clk_out, clk_en} !== ones) $display("FAIL rst_reconf_clk got=%b want=%b", {clk_out, clk_en}, ones);
      else n_pass++;
      cfg_bus.cfg_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 20; k++) begin
         n_total++;
         if ({clk_out, clk_en} !== {exp_out(cyc), exp_en(cyc)})
            $display("FAIL post_rst_clk cyc=%0d got=%b want=%b", cyc, {clk_out, clk_en}, {exp_out(cyc), exp_en(cyc)});
         else n_pass++;
         n_total++;
         if ({locked, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== exp_status(cyc))
            $display("FAIL post_rst_stat cyc=%0d got=%b want=%b", cyc, {locked, cfg_bus.cfg_ready, cfg_bus.cfg_err}, exp_status(cyc));
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_reconfig();
      test_phase();
      test_invalid();
      test_hold_and_div1();
      test_random();
      test_reset_in_reconf();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
